// File: rtl/defines.sv
// Shared width definitions for the unified-buffer feed path.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 32
`endif

// File: rtl/ub_feed_sequencer.sv
// ub_feed_sequencer: accepts a tile command and streams paired input/weight
// row addresses into the unified buffer. Host writes are accepted only while
// idle. Outputs to the buffer are registered, so a beat computed in a STREAM
// cycle appears on the ports in the following cycle.
`include "defines.sv"

module ub_feed_sequencer #(
   parameter int LEN_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [`ADDR_WIDTH-1:0]     cmd_input_base,
   input  logic [`ADDR_WIDTH-1:0]     cmd_weight_base,
   input  logic [LEN_W-1:0]           cmd_len,
   input  logic                       stall,
   input  logic                       host_wr_valid,
   output logic                       host_wr_ready,
   input  logic [`ADDR_WIDTH-1:0]     host_wr_addr,
   input  logic [`BUFFER_WIDTH-1:0]   host_wr_data,
   output logic                       ub_wr_en,
   output logic [`ADDR_WIDTH-1:0]     ub_wr_addr,
   output logic [`BUFFER_WIDTH-1:0]   ub_wr_data,
   output logic [`ADDR_WIDTH-1:0]     input_addr,
   output logic [`ADDR_WIDTH-1:0]     weight_addr,
   output logic                       input_first,
   output logic                       input_last,
   output logic                       weight_first,
   output logic                       weight_last,
   output logic                       issue,
   output logic                       busy,
   output logic                       done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [LEN_W-1:0]         k_q, k_d;
   logic [LEN_W-1:0]         len_q, len_d;
   logic [`ADDR_WIDTH-1:0]   ibase_q, ibase_d;
   logic [`ADDR_WIDTH-1:0]   wbase_q, wbase_d;
   logic [`ADDR_WIDTH-1:0]   input_addr_q, input_addr_d;
   logic [`ADDR_WIDTH-1:0]   weight_addr_q, weight_addr_d;
   logic                     first_q, first_d;
   logic                     last_q, last_d;
   logic                     issue_q, issue_d;
   logic                     done_q, done_d;

   logic                     idle_s;
   logic                     cmd_fire_s;
   logic                     is_last_s;

   // Handshake decode: a pending host write blocks command acceptance.
   assign idle_s        = (state_q == IDLE);
   assign host_wr_ready = idle_s;
   assign cmd_ready     = idle_s && !host_wr_valid;
   assign cmd_fire_s    = cmd_valid && cmd_ready;
   assign ub_wr_en      = host_wr_valid && host_wr_ready;
   assign ub_wr_addr    = host_wr_addr;
   assign ub_wr_data    = host_wr_data;
   assign busy          = !idle_s;
   assign is_last_s     = (k_q == (len_q - {{(LEN_W-1){1'b0}}, 1'b1}));

   assign input_addr    = input_addr_q;
   assign weight_addr   = weight_addr_q;
   assign input_first   = first_q;
   assign weight_first  = first_q;
   assign input_last    = last_q;
   assign weight_last   = last_q;
   assign issue         = issue_q;
   assign done          = done_q;

   // Next-state, beat counter and registered-output computation.
   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      len_d         = len_q;
      ibase_d       = ibase_q;
      wbase_d       = wbase_q;
      input_addr_d  = input_addr_q;
      weight_addr_d = weight_addr_q;
      first_d       = 1'b0;
      last_d        = 1'b0;
      issue_d       = 1'b0;
      done_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_fire_s) begin
               if (cmd_len != {LEN_W{1'b0}}) begin
                  ibase_d = cmd_input_base;
                  wbase_d = cmd_weight_base;
                  len_d   = cmd_len;
                  k_d     = {LEN_W{1'b0}};
                  state_d = STREAM;
               end else begin
                  // Empty tile: nothing to stream, just report completion.
                  done_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         STREAM: begin
            // During a stall the pending beat's address is shown but not issued.
            input_addr_d  = ibase_q + `ADDR_WIDTH'(k_q);
            weight_addr_d = wbase_q + `ADDR_WIDTH'(k_q);
            if (!stall) begin
               issue_d = 1'b1;
               first_d = (k_q == {LEN_W{1'b0}});
               last_d  = is_last_s;
               if (is_last_s) begin
                  state_d = DRAIN;
               end else begin
                  k_d = k_q + {{(LEN_W-1){1'b0}}, 1'b1};
               end
            end else begin
               k_d = k_q;
            end
         end
         DRAIN: begin
            // Last beat's data reaches the buffer output one cycle after issue.
            done_d  = 1'b1;
            k_d     = {LEN_W{1'b0}};
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         k_q           <= {LEN_W{1'b0}};
         len_q         <= {LEN_W{1'b0}};
         ibase_q       <= {`ADDR_WIDTH{1'b0}};
         wbase_q       <= {`ADDR_WIDTH{1'b0}};
         input_addr_q  <= {`ADDR_WIDTH{1'b0}};
         weight_addr_q <= {`ADDR_WIDTH{1'b0}};
         first_q       <= 1'b0;
         last_q        <= 1'b0;
         issue_q       <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         len_q         <= len_d;
         ibase_q       <= ibase_d;
         wbase_q       <= wbase_d;
         input_addr_q  <= input_addr_d;
         weight_addr_q <= weight_addr_d;
         first_q       <= first_d;
         last_q        <= last_d;
         issue_q       <= issue_d;
         done_q        <= done_d;
      end
   end

endmodule

// File: tb/tb_ub_feed_sequencer.sv
// Directed bench for ub_feed_sequencer: basic tile, stall, wrap, len=1,
// host/command arbitration, zero length and mid-stream reset.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 32
`endif

module tb_ub_feed_sequencer;

   localparam int LEN_W = 8;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [`ADDR_WIDTH-1:0]   cmd_input_base;
   logic [`ADDR_WIDTH-1:0]   cmd_weight_base;
   logic [LEN_W-1:0]         cmd_len;
   logic                     stall;
   logic                     host_wr_valid;
   logic                     host_wr_ready;
   logic [`ADDR_WIDTH-1:0]   host_wr_addr;
   logic [`BUFFER_WIDTH-1:0] host_wr_data;
   logic                     ub_wr_en;
   logic [`ADDR_WIDTH-1:0]   ub_wr_addr;
   logic [`BUFFER_WIDTH-1:0] ub_wr_data;
   logic [`ADDR_WIDTH-1:0]   input_addr;
   logic [`ADDR_WIDTH-1:0]   weight_addr;
   logic                     input_first, input_last, weight_first, weight_last;
   logic                     issue, busy, done;

   int errors = 0;
   int checks = 0;

   ub_feed_sequencer #(.LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_input_base(cmd_input_base), .cmd_weight_base(cmd_weight_base),
      .cmd_len(cmd_len), .stall(stall),
      .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
      .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
      .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data),
      .input_addr(input_addr), .weight_addr(weight_addr),
      .input_first(input_first), .input_last(input_last),
      .weight_first(weight_first), .weight_last(weight_last),
      .issue(issue), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks one issued (or stalled) beat: issue, both addresses, markers.
   task automatic check_beat(input string tag, input logic iss,
                             input logic [7:0] ia, input logic [7:0] wa,
                             input logic f, input logic l);
      check({tag, "_issue"}, {31'd0, issue}, {31'd0, iss});
      check({tag, "_iaddr"}, {24'd0, input_addr}, {24'd0, ia});
      check({tag, "_waddr"}, {24'd0, weight_addr}, {24'd0, wa});
      check({tag, "_ifirst"}, {31'd0, input_first}, {31'd0, f});
      check({tag, "_wfirst"}, {31'd0, weight_first}, {31'd0, f});
      check({tag, "_ilast"}, {31'd0, input_last}, {31'd0, l});
      check({tag, "_wlast"}, {31'd0, weight_last}, {31'd0, l});
   endtask

   task automatic send_cmd(input logic [7:0] ib, input logic [7:0] wb, input logic [7:0] len);
      cmd_valid       = 1'b1;
      cmd_input_base  = ib;
      cmd_weight_base = wb;
      cmd_len         = len;
      #1;
      check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      int busy_cnt;
      rst = 1'b1; cmd_valid = 1'b0; cmd_input_base = 8'h00; cmd_weight_base = 8'h00;
      cmd_len = 8'd0; stall = 1'b0; host_wr_valid = 1'b0; host_wr_addr = 8'h00;
      host_wr_data = 32'h0;
      tick(); tick();
      // Reset state
      check("rst_busy", {31'd0, busy}, 32'd0);
      check_beat("rst", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_hwr_ready", {31'd0, host_wr_ready}, 32'd1);
      rst = 1'b0;
      tick();

      // Basic tile: ibase 0x10, wbase 0x40, len 4
      send_cmd(8'h10, 8'h40, 8'd4);
      busy_cnt = 0;
      if (busy) busy_cnt++;
      check("basic_no_issue_yet", {31'd0, issue}, 32'd0);
      for (int b = 0; b < 4; b++) begin
         tick();
         if (busy) busy_cnt++;
         check_beat($sformatf("basic_b%0d", b), 1'b1, 8'h10 + 8'(b), 8'h40 + 8'(b),
                    b == 0, b == 3);
         check("basic_no_early_done", {31'd0, done}, 32'd0);
      end
      tick();
      check("basic_done", {31'd0, done}, 32'd1);
      check_beat("basic_after", 1'b0, 8'h13, 8'h43, 1'b0, 1'b0);
      check("basic_busy_cycles", busy_cnt, 32'd5);
      check("basic_idle", {31'd0, busy}, 32'd0);
      tick();
      check("basic_done_pulse", {31'd0, done}, 32'd0);

      // Stall: len 3, stall for 2 cycles while beat 1 is pending
      send_cmd(8'h20, 8'h60, 8'd3);
      tick();
      check_beat("stall_b0", 1'b1, 8'h20, 8'h60, 1'b1, 1'b0);
      stall = 1'b1;
      tick();
      check_beat("stall_s0", 1'b0, 8'h21, 8'h61, 1'b0, 1'b0);
      tick();
      check_beat("stall_s1", 1'b0, 8'h21, 8'h61, 1'b0, 1'b0);
      stall = 1'b0;
      tick();
      check_beat("stall_b1", 1'b1, 8'h21, 8'h61, 1'b0, 1'b0);
      tick();
      check_beat("stall_b2", 1'b1, 8'h22, 8'h62, 1'b0, 1'b1);
      check("stall_no_early_done", {31'd0, done}, 32'd0);
      stall = 1'b1;   // ignored in DRAIN
      tick();
      check("stall_drain_noissue", {31'd0, issue}, 32'd0);
      check("stall_done", {31'd0, done}, 32'd1);
      stall = 1'b0;
      tick();

      // Address wrap: ibase 0xFF, len 2
      send_cmd(8'hFF, 8'h80, 8'd2);
      tick();
      check_beat("wrap_b0", 1'b1, 8'hFF, 8'h80, 1'b1, 1'b0);
      tick();
      check_beat("wrap_b1", 1'b1, 8'h00, 8'h81, 1'b0, 1'b1);
      tick();
      check("wrap_done", {31'd0, done}, 32'd1);
      tick();

      // Arbitration: host write wins the tie, command follows, then len=1 tile
      host_wr_valid = 1'b1; host_wr_addr = 8'h5A; host_wr_data = 32'hDEAD_BEEF;
      cmd_valid = 1'b1; cmd_input_base = 8'h30; cmd_weight_base = 8'h70; cmd_len = 8'd1;
      #1;
      check("arb_wr_en", {31'd0, ub_wr_en}, 32'd1);
      check("arb_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("arb_wr_addr", {24'd0, ub_wr_addr}, 32'h5A);
      check("arb_wr_data", ub_wr_data, 32'hDEAD_BEEF);
      tick();
      check("arb_still_idle", {31'd0, busy}, 32'd0);
      host_wr_valid = 1'b0;
      #1;
      check("arb_cmd_ready2", {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
      host_wr_valid = 1'b1;
      #1;
      check("arb_busy", {31'd0, busy}, 32'd1);
      check("arb_hwr_ready_busy", {31'd0, host_wr_ready}, 32'd0);
      check("arb_wr_blocked", {31'd0, ub_wr_en}, 32'd0);
      tick();
      check_beat("len1_b0", 1'b1, 8'h30, 8'h70, 1'b1, 1'b1);
      tick();
      check("len1_done", {31'd0, done}, 32'd1);
      host_wr_valid = 1'b0;
      tick();

      // Zero length: done next cycle, no issue, stay idle
      send_cmd(8'h11, 8'h22, 8'd0);
      check("len0_done", {31'd0, done}, 32'd1);
      check("len0_issue", {31'd0, issue}, 32'd0);
      check("len0_busy", {31'd0, busy}, 32'd0);
      tick();
      check("len0_done_pulse", {31'd0, done}, 32'd0);

      // Reset during beat 2 of a len 8 tile
      send_cmd(8'h50, 8'h90, 8'd8);
      tick();
      tick();
      check_beat("rstm_b1", 1'b1, 8'h51, 8'h91, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstm_busy", {31'd0, busy}, 32'd0);
      check_beat("rstm", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      check("rstm_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("rstm_no_done", {30'd0, done, issue}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
